// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle between the four requesters and the register-bank write arbiter.
// Latency: none, wires only; gnt/load/wdata/wr_valid/ptr are registered inside the arbiter.
// Backpressure: stall freezes new grants; req is a level held until its gnt is seen.
interface rf_write_arbiter_if #(
  parameter int DW   = 32,
  parameter int AW   = 4,
  parameter int NREQ = 4
);
  localparam int NL = 2**AW;

  logic                 stall;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata_in;
  logic [NREQ-1:0]      gnt;
  logic [NL-1:0]        load;
  logic [DW-1:0]        wdata;
  logic                 wr_valid;
  logic [1:0]           ptr;

  // Requester side: drives requests and stall, observes grant and bank-facing outputs.
  modport master (
    output stall, req, addr, wdata_in,
    input  gnt, load, wdata, wr_valid, ptr
  );

  // Arbiter side.
  modport slave (
    input  stall, req, addr, wdata_in,
    output gnt, load, wdata, wr_valid, ptr
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter driving the single write port (one-hot load + data) of the register bank.
// Latency: request eligible before edge N -> gnt/load/wdata valid cycle N..N+1; bank captures at N+1.
// Backpressure: stall=1 blocks new grants (requests stay pending); a registered grant always completes.
module rf_write_arbiter #(
  parameter int DW   = 32,
  parameter int AW   = 4,
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               reset_,
  rf_write_arbiter_if.slave  bus
);

  localparam int NL = 2**AW;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NL-1:0]   load_q, load_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            wr_valid_q, wr_valid_d;
  logic [1:0]      ptr_q, ptr_d;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // A requester still seeing its own grant is skipped so a late-dropping req is not granted twice.
  assign elig = bus.req & ~gnt_q;

  // Scan from ptr upward (mod 4); walking offsets high-to-low leaves the nearest eligible index.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Only the winner's slice is selected, so X/Z on other requesters' lanes never reaches the bank.
  assign win_addr = bus.addr[win*AW +: AW];
  assign win_data = bus.wdata_in[win*DW +: DW];

  // Next-state: issue one grant with decoded load enable, or idle while keeping wdata and ptr.
  always_comb begin
    gnt_d      = '0;
    load_d     = '0;
    wdata_d    = wdata_q;
    wr_valid_d = 1'b0;
    ptr_d      = ptr_q;
    if (!bus.stall && found) begin
      gnt_d[win]      = 1'b1;
      load_d[win_addr] = 1'b1;
      wdata_d         = win_data;
      wr_valid_d      = 1'b1;
      ptr_d           = win + 2'd1;
    end
  end

  // Output registers; async reset drops any in-flight write immediately.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      gnt_q      <= '0;
      load_q     <= '0;
      wdata_q    <= '0;
      wr_valid_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      gnt_q      <= gnt_d;
      load_q     <= load_d;
      wdata_q    <= wdata_d;
      wr_valid_q <= wr_valid_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.load     = load_q;
  assign bus.wdata    = wdata_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.ptr      = ptr_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized protocol-following traffic.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stall driven randomly; requesters hold req/addr/data until granted.
module tb_rf_write_arbiter;
  localparam int DW = 32, AW = 4, NREQ = 4, NL = 16;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DW(DW), .AW(AW), .NREQ(NREQ)) bif ();
  rf_write_arbiter #(.DW(DW), .AW(AW), .NREQ(NREQ)) dut (.clk(clk), .reset_(reset_), .bus(bif));

  int checks = 0;
  int errors = 0;

  // Expected state kept by the bench
  logic [NREQ-1:0] m_gnt;
  logic [NL-1:0]   m_load;
  logic [DW-1:0]   m_wdata;
  logic            m_valid;
  int              m_ptr;

  // Register bank fed by the arbiter outputs
  logic [DW-1:0] bank [NL];
  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < NL; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < NL; i++) if (bif.load[i]) bank[i] <= bif.wdata;
    end
  end

  task automatic model_reset();
    m_gnt = '0; m_load = '0; m_wdata = '0; m_valid = 1'b0; m_ptr = 0;
  endtask

  // Winner = eligible requester with smallest round-robin distance from ptr.
  task automatic model_edge();
    int best, bestd, d;
    logic [AW-1:0] a;
    best = -1; bestd = NREQ;
    if (!bif.stall) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bif.req[i] && !m_gnt[i]) begin
          d = (i - m_ptr + NREQ) % NREQ;
          if (d < bestd) begin bestd = d; best = i; end
        end
      end
    end
    if (best >= 0) begin
      a = bif.addr[best*AW +: AW];
      m_gnt = '0; m_gnt[best] = 1'b1;
      m_load = '0; m_load[a] = 1'b1;
      m_wdata = bif.wdata_in[best*DW +: DW];
      m_valid = 1'b1;
      m_ptr = (best + 1) % NREQ;
    end else begin
      m_gnt = '0; m_load = '0; m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bif.addr[i*AW +: AW] = a;
    bif.wdata_in[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    bif.req = '0; bif.stall = 1'b0;
    model_reset();
    #2;
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bif.gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", bif.gnt); end
    checks++; if (bif.load !== 16'h0) begin errors++; $display("FAIL reset_load: got %h want 0", bif.load); end
    checks++; if (bif.wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bif.wdata); end
    checks++; if (bif.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", bif.wr_valid); end
    checks++; if (bif.ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", bif.ptr); end
    #3 reset_ = 1'b1;
    tick();
    set_req(0, 4'd3, 32'h1234_5678);
    bif.req = 4'b0001;
    tick();
    checks++; if (bif.gnt !== 4'b0001) begin errors++; $display("FAIL pre_reset_gnt: got %b want 0001", bif.gnt); end
    // Reset lands mid-cycle while the grant is outstanding
    #2 reset_ = 1'b0;
    #1;
    checks++; if (bif.gnt !== 4'b0) begin errors++; $display("FAIL midreset_gnt: got %b want 0", bif.gnt); end
    checks++; if (bif.load !== 16'h0) begin errors++; $display("FAIL midreset_load: got %h want 0", bif.load); end
    checks++; if (bif.wdata !== 32'h0) begin errors++; $display("FAIL midreset_wdata: got %h want 0", bif.wdata); end
    checks++; if (bif.wr_valid !== 1'b0) begin errors++; $display("FAIL midreset_wr_valid: got %b want 0", bif.wr_valid); end
    checks++; if (bif.ptr !== 2'd0) begin errors++; $display("FAIL midreset_ptr: got %0d want 0", bif.ptr); end
    model_reset();
    #1 reset_ = 1'b1;
    // req still high: first edge behaves as ptr=0 with no grant outstanding
    tick();
    checks++; if (bif.gnt !== 4'b0001) begin errors++; $display("FAIL postreset_gnt: got %b want 0001", bif.gnt); end
    checks++; if (bif.ptr !== 2'd1) begin errors++; $display("FAIL postreset_ptr: got %0d want 1", bif.ptr); end
    bif.req = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 4'd7, 32'hDEAD_BEEF);
    bif.req = 4'b0100;
    tick();
    checks++; if (bif.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", bif.gnt); end
    checks++; if (bif.load !== 16'h0080) begin errors++; $display("FAIL single_load: got %h want 0080", bif.load); end
    checks++; if (bif.wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdata: got %h want deadbeef", bif.wdata); end
    checks++; if (bif.wr_valid !== 1'b1) begin errors++; $display("FAIL single_wr_valid: got %b want 1", bif.wr_valid); end
    checks++; if (bif.ptr !== 2'd3) begin errors++; $display("FAIL single_ptr: got %0d want 3", bif.ptr); end
    bif.req = '0;
    tick();
    checks++; if (bif.gnt !== 4'b0 || bif.wr_valid !== 1'b0 || bif.load !== 16'h0) begin
      errors++; $display("FAIL single_idle: got gnt=%b vld=%b load=%h want 0/0/0", bif.gnt, bif.wr_valid, bif.load);
    end
    checks++; if (bif.wdata !== 32'hDEAD_BEEF || bif.ptr !== 2'd3) begin
      errors++; $display("FAIL single_hold: got wdata=%h ptr=%0d want deadbeef/3", bif.wdata, bif.ptr);
    end
  endtask

  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 32'(100 + i));
    bif.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      e = '0; e[order[k]] = 1'b1;
      checks++; if (bif.gnt !== e) begin errors++; $display("FAIL fair_gnt%0d: got %b want %b", k, bif.gnt, e); end
      checks++; if (bif.wdata !== 32'(100 + order[k])) begin errors++; $display("FAIL fair_wdata%0d: got %0d want %0d", k, bif.wdata, 100 + order[k]); end
    end
    bif.req = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    set_req(1, 4'd2, 32'hCAFE_0001);
    bif.req = 4'b0010;
    bif.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bif.gnt !== 4'b0 || bif.ptr !== 2'd0) begin
        errors++; $display("FAIL stall_hold%0d: got gnt=%b ptr=%0d want 0/0", k, bif.gnt, bif.ptr);
      end
    end
    bif.stall = 1'b0;
    tick();
    checks++; if (bif.gnt !== 4'b0010) begin errors++; $display("FAIL stall_release_gnt: got %b want 0010", bif.gnt); end
    checks++; if (bif.load !== 16'h0004) begin errors++; $display("FAIL stall_release_load: got %h want 0004", bif.load); end
    // Stall raised during a registered grant does not cancel it
    bif.req = '0;
    bif.stall = 1'b1;
    #2;
    checks++; if (bif.gnt !== 4'b0010 || bif.wr_valid !== 1'b1) begin
      errors++; $display("FAIL stall_no_cancel: got gnt=%b vld=%b want 0010/1", bif.gnt, bif.wr_valid);
    end
    tick();
    bif.stall = 1'b0;
    checks++; if (bank[2] !== 32'hCAFE_0001) begin errors++; $display("FAIL stall_bank: got %h want cafe0001", bank[2]); end
  endtask

  task automatic test_same_addr();
    do_reset();
    set_req(0, 4'd5, 32'h1);
    set_req(1, 4'd5, 32'h2);
    bif.req = 4'b0011;
    tick();
    checks++; if (bif.gnt !== 4'b0001 || bif.load !== 16'h0020 || bif.wdata !== 32'h1) begin
      errors++; $display("FAIL same_first: got gnt=%b load=%h wdata=%h want 0001/0020/1", bif.gnt, bif.load, bif.wdata);
    end
    bif.req = 4'b0010;
    tick();
    checks++; if (bif.gnt !== 4'b0010 || bif.load !== 16'h0020 || bif.wdata !== 32'h2) begin
      errors++; $display("FAIL same_second: got gnt=%b load=%h wdata=%h want 0010/0020/2", bif.gnt, bif.load, bif.wdata);
    end
    bif.req = '0;
    tick();
    checks++; if (bank[5] !== 32'h2) begin errors++; $display("FAIL same_bank: got %h want 2", bank[5]); end
  endtask

  task automatic test_boundary();
    do_reset();
    set_req(2, 4'd15, 32'hF00D_0015);
    bif.req = 4'b0100;
    tick();
    checks++; if (bif.load !== 16'h8000) begin errors++; $display("FAIL bnd_decode: got %h want 8000", bif.load); end
    checks++; if (bif.ptr !== 2'd3) begin errors++; $display("FAIL bnd_ptr3: got %0d want 3", bif.ptr); end
    bif.req = '0;
    tick();
    set_req(3, 4'd9, 32'h3333_3333);
    set_req(0, 4'd15, 32'h0000_0F0F);
    bif.req = 4'b1001;
    tick();
    checks++; if (bif.gnt !== 4'b1000 || bif.load !== 16'h0200) begin
      errors++; $display("FAIL bnd_req3: got gnt=%b load=%h want 1000/0200", bif.gnt, bif.load);
    end
    checks++; if (bif.ptr !== 2'd0) begin errors++; $display("FAIL bnd_wrap: got %0d want 0", bif.ptr); end
    bif.req = 4'b0001;
    tick();
    checks++; if (bif.gnt !== 4'b0001 || bif.load !== 16'h8000 || bif.wdata !== 32'h0000_0F0F) begin
      errors++; $display("FAIL bnd_req0: got gnt=%b load=%h wdata=%h want 0001/8000/00000f0f", bif.gnt, bif.load, bif.wdata);
    end
    checks++; if (bif.ptr !== 2'd1) begin errors++; $display("FAIL bnd_ptr1: got %0d want 1", bif.ptr); end
    bif.req = '0;
    tick();
  endtask

  task automatic test_random();
    int waitc [NREQ];
    logic [NREQ-1:0] req_before;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      waitc[i] = 0;
      set_req(i, 'x, 'x);
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bif.req[i]) begin
          if (m_gnt[i]) begin
            if ($urandom_range(1, 0) == 1) set_req(i, AW'($urandom), $urandom);
            else begin bif.req[i] = 1'b0; set_req(i, 'x, 'x); end
          end
        end else if ($urandom_range(2, 0) == 0) begin
          bif.req[i] = 1'b1;
          set_req(i, AW'($urandom), $urandom);
        end
      end
      bif.stall = ($urandom_range(4, 0) == 0);
      req_before = bif.req;
      tick();
      checks++;
      if (bif.gnt !== m_gnt || bif.load !== m_load || bif.wdata !== m_wdata ||
          bif.wr_valid !== m_valid || bif.ptr !== 2'(m_ptr)) begin
        errors++;
        $display("FAIL rand_cyc%0d: got gnt=%b load=%h wdata=%h vld=%b ptr=%0d want %b/%h/%h/%b/%0d",
                 cyc, bif.gnt, bif.load, bif.wdata, bif.wr_valid, bif.ptr, m_gnt, m_load, m_wdata, m_valid, m_ptr);
      end
      checks++;
      if (!$onehot0(bif.gnt) || !$onehot0(bif.load) || (bif.wr_valid !== |bif.load) || (bif.wr_valid !== |bif.gnt)) begin
        errors++; $display("FAIL rand_invariant%0d: got gnt=%b load=%h vld=%b", cyc, bif.gnt, bif.load, bif.wr_valid);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_before[i]) begin
          if (bif.gnt[i]) waitc[i] = 0;
          else if (|bif.gnt) waitc[i]++;
          checks++;
          if (waitc[i] > 3) begin errors++; $display("FAIL rand_starve%0d_r%0d: got wait=%0d want <=3", cyc, i, waitc[i]); end
        end else begin
          waitc[i] = 0;
        end
      end
    end
    bif.req = '0;
    bif.stall = 1'b0;
    tick();
  endtask

  initial begin
    reset_ = 1'b0;
    bif.stall = 1'b0;
    bif.req = '0;
    bif.addr = '0;
    bif.wdata_in = '0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_same_addr();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
